ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// Shares the single-port synchronous RAM (registered read, 1-cycle write) between three pipeline requesters:
// stage12 fetch read, stage3 operand read, stage5 store write. Sits between the stage modules and the ram instance.
// Serialises accesses with fixed priority (stage5 > stage3 > stage12) plus an anti-starvation counter per reader.
// PARAMETERS
// ADDR_W        16  RAM address width
// DATA_W        8   RAM data width
// STARVE_LIMIT  4   lost arbitrations before a pending reader is promoted to top priority; 0 = pure fixed priority
// PORTS
// ram_clk                 in   1       single clock, all logic on posedge
// rst                     in   1       synchronous reset, active-low
// stage12_read            in   1       fetch read request (level, held until ready)
// stage12_read_address    in   ADDR_W  fetch address, stable while request high
// stage12_read_ready      out  1       1-cycle pulse: access done, data valid
// stage12_read_data_out   out  DATA_W  read data, held until next stage12 completion
// stage3_read / _address / _ready / _data_out   same as stage12 set, for stage3
// stage5_save             in   1       store request (level, held until ready)
// stage5_save_address     in   ADDR_W  store address
// stage5_save_data_in     in   DATA_W  store data
// stage5_save_ready       out  1       1-cycle pulse: write committed
// ram_write_enable        out  1       to ram.write_enable
// ram_address             out  ADDR_W  to ram.address
// ram_data_in             out  DATA_W  to ram.data_in
// ram_data_out            in   DATA_W  from ram.data_out
// busy                    out  1       high in ACCESS/CAPTURE
// BEHAVIOUR
// - Reset (rst==0 at posedge): state IDLE, all outputs 0 (readies, data_outs, ram_*, busy), starve counters 0, served mask clear.
// - FSM IDLE -> ACCESS -> CAPTURE -> IDLE. All outputs registered.
// - IDLE: sample requests at posedge; if any eligible, latch winner id, drive ram_address (and ram_data_in,
//   ram_write_enable=1 for stage5), go ACCESS. No request: stay IDLE, ram_write_enable=0.
// - ACCESS: RAM performs access at the edge leaving ACCESS; arbiter drops ram_write_enable to 0, goes CAPTURE.
// - CAPTURE: at leaving edge, reader winner latches ram_data_out into its data_out; winner ready=1 for exactly
//   one cycle (the following IDLE cycle); go IDLE.
// - Latency: request first sampled at edge N (IDLE) -> ready high after edge N+2, low after N+3. Throughput: 1 access / 3 cycles.
// - Served mask: during the IDLE cycle in which ready is high, the just-served requester is ineligible (its request
//   may still be high); requester must drop request in that cycle to avoid a second access.
// - Priority: any promoted reader (counter>=STARVE_LIMIT, limit!=0) first, stage3 before stage12 if both promoted;
//   else stage5 > stage3 > stage12.
// - Starve counters (stage3, stage12): +1 per grant to another requester while own request pending and eligible;
//   saturate at STARVE_LIMIT; clear on own grant or when own request low.
// - Inputs latched only in IDLE; address/data changes after grant are ignored.
// - Request dropped before grant: not served, no ready. Dropped after grant: access completes, ready still pulses.
// - Simultaneous requests from all three: served in priority order, one per 3 cycles, no request lost.
// - Reset mid-operation: next edge returns IDLE, no ready pulse; a write already issued in ACCESS
//   may have committed (RAM sampled at that edge); none issued after reset.
// - stage5 write never alters stage12/stage3 data_out registers.
// TESTING
// 1 Lone stage12 read of addr 0x0010 (RAM=0x2A) -> ram_address=0x0010 after edge N, ready after N+2, data_out=0x2A.
// 2 stage5 save addr 0x0100 data 0x55 then stage3 read 0x0100 -> write_enable high one cycle, stage3 data_out=0x55.
// 3 All three request same cycle, held -> grant order stage5, stage3, stage12; readies 3 cycles apart.
// 4 STARVE_LIMIT=2, stage5 re-requests continuously, stage12 pending -> stage12 granted after 2 stage5 grants.
// 5 rst=0 during ACCESS of stage12 read -> next edge IDLE, all outputs 0, no stage12_read_ready pulse.
// 6 stage3 request held high through ready cycle -> no second access that cycle; stage12 pending granted instead.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the single-port RAM.
// Ports (signals):
//   stage12_read / _address / _ready / _data_out : fetch read requester
//   stage3_read  / _address / _ready / _data_out : operand read requester
//   stage5_save / _address / _data_in / _ready   : store write requester
//   ram_write_enable / ram_address / ram_data_in / ram_data_out : RAM side
//   busy : arbiter has an access in flight
// Modports: slave = arbiter view, master = stages + RAM view.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              stage12_read;
  logic [ADDR_W-1:0] stage12_read_address;
  logic              stage12_read_ready;
  logic [DATA_W-1:0] stage12_read_data_out;

  logic              stage3_read;
  logic [ADDR_W-1:0] stage3_read_address;
  logic              stage3_read_ready;
  logic [DATA_W-1:0] stage3_read_data_out;

  logic              stage5_save;
  logic [ADDR_W-1:0] stage5_save_address;
  logic [DATA_W-1:0] stage5_save_data_in;
  logic              stage5_save_ready;

  logic              ram_write_enable;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  logic              busy;

  modport slave (
    input  stage12_read, stage12_read_address,
    output stage12_read_ready, stage12_read_data_out,
    input  stage3_read, stage3_read_address,
    output stage3_read_ready, stage3_read_data_out,
    input  stage5_save, stage5_save_address, stage5_save_data_in,
    output stage5_save_ready,
    output ram_write_enable, ram_address, ram_data_in,
    input  ram_data_out,
    output busy
  );

  modport master (
    output stage12_read, stage12_read_address,
    input  stage12_read_ready, stage12_read_data_out,
    output stage3_read, stage3_read_address,
    input  stage3_read_ready, stage3_read_data_out,
    output stage5_save, stage5_save_address, stage5_save_data_in,
    input  stage5_save_ready,
    input  ram_write_enable, ram_address, ram_data_in,
    output ram_data_out,
    input  busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM (registered read, 1-cycle write) between
// the stage12 fetch reader, the stage3 operand reader and the stage5 store writer.
// One access per IDLE -> ACCESS -> CAPTURE round; fixed priority stage5 > stage3 >
// stage12, with readers promoted to top priority after STARVE_LIMIT lost arbitrations.
// Ports:
//   ram_clk : clock, all logic on posedge
//   rst     : synchronous reset, active-low
//   bus     : ram_port_arbiter_if.slave (requests, readies, read data, RAM bus, busy)
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              ram_clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int unsigned    CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] ID_S12 = 2'd0;
  localparam logic [1:0] ID_S3  = 2'd1;
  localparam logic [1:0] ID_S5  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t             r_state,   w_state_nxt;
  logic [1:0]         r_win,     w_win_nxt;
  logic [2:0]         r_served,  w_served_nxt;   // {stage5, stage3, stage12}
  logic [CNT_W-1:0]   r_cnt3,    w_cnt3_nxt;
  logic [CNT_W-1:0]   r_cnt12,   w_cnt12_nxt;
  logic               r_we,      w_we_nxt;
  logic [ADDR_W-1:0]  r_addr,    w_addr_nxt;
  logic [DATA_W-1:0]  r_din,     w_din_nxt;
  logic               r_rdy12,   w_rdy12_nxt;
  logic               r_rdy3,    w_rdy3_nxt;
  logic               r_rdy5,    w_rdy5_nxt;
  logic [DATA_W-1:0]  r_d12,     w_d12_nxt;
  logic [DATA_W-1:0]  r_d3,      w_d3_nxt;
  logic               r_busy,    w_busy_nxt;

  logic [2:0] w_req;
  logic [2:0] w_elig;
  logic       w_prom3;
  logic       w_prom12;

  // The requester whose ready is high this cycle sits out this arbitration.
  assign w_req    = {bus.stage5_save, bus.stage3_read, bus.stage12_read};
  assign w_elig   = w_req & ~r_served;
  assign w_prom3  = (STARVE_LIMIT != 0) && w_elig[1] && (r_cnt3  >= LIMIT);
  assign w_prom12 = (STARVE_LIMIT != 0) && w_elig[0] && (r_cnt12 >= LIMIT);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_win_nxt    = r_win;
    w_served_nxt = 3'b000;
    w_cnt3_nxt   = r_cnt3;
    w_cnt12_nxt  = r_cnt12;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_din_nxt    = r_din;
    w_rdy12_nxt  = 1'b0;
    w_rdy3_nxt   = 1'b0;
    w_rdy5_nxt   = 1'b0;
    w_d12_nxt    = r_d12;
    w_d3_nxt     = r_d3;

    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          if (w_prom3)        w_win_nxt = ID_S3;
          else if (w_prom12)  w_win_nxt = ID_S12;
          else if (w_elig[2]) w_win_nxt = ID_S5;
          else if (w_elig[1]) w_win_nxt = ID_S3;
          else                w_win_nxt = ID_S12;

          case (w_win_nxt)
            ID_S5: begin
              w_we_nxt   = 1'b1;
              w_addr_nxt = bus.stage5_save_address;
              w_din_nxt  = bus.stage5_save_data_in;
            end
            ID_S3:   w_addr_nxt = bus.stage3_read_address;
            default: w_addr_nxt = bus.stage12_read_address;
          endcase

          // A pending, eligible reader that loses this grant ages by one.
          if (w_win_nxt == ID_S3)             w_cnt3_nxt = '0;
          else if (w_elig[1] && r_cnt3 < LIMIT) w_cnt3_nxt = r_cnt3 + CNT_W'(1);
          if (w_win_nxt == ID_S12)             w_cnt12_nxt = '0;
          else if (w_elig[0] && r_cnt12 < LIMIT) w_cnt12_nxt = r_cnt12 + CNT_W'(1);

          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        // RAM read data is valid now; hand it to the winner and pulse its ready.
        w_state_nxt = ST_IDLE;
        case (r_win)
          ID_S5: begin
            w_rdy5_nxt   = 1'b1;
            w_served_nxt = 3'b100;
          end
          ID_S3: begin
            w_rdy3_nxt   = 1'b1;
            w_d3_nxt     = bus.ram_data_out;
            w_served_nxt = 3'b010;
          end
          default: begin
            w_rdy12_nxt  = 1'b1;
            w_d12_nxt    = bus.ram_data_out;
            w_served_nxt = 3'b001;
          end
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (!w_req[1]) w_cnt3_nxt  = '0;
    if (!w_req[0]) w_cnt12_nxt = '0;

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_win    <= ID_S12;
      r_served <= 3'b000;
      r_cnt3   <= '0;
      r_cnt12  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_rdy12  <= 1'b0;
      r_rdy3   <= 1'b0;
      r_rdy5   <= 1'b0;
      r_d12    <= '0;
      r_d3     <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_win    <= w_win_nxt;
      r_served <= w_served_nxt;
      r_cnt3   <= w_cnt3_nxt;
      r_cnt12  <= w_cnt12_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_din    <= w_din_nxt;
      r_rdy12  <= w_rdy12_nxt;
      r_rdy3   <= w_rdy3_nxt;
      r_rdy5   <= w_rdy5_nxt;
      r_d12    <= w_d12_nxt;
      r_d3     <= w_d3_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.stage12_read_ready    = r_rdy12;
  assign bus.stage12_read_data_out = r_d12;
  assign bus.stage3_read_ready     = r_rdy3;
  assign bus.stage3_read_data_out  = r_d3;
  assign bus.stage5_save_ready     = r_rdy5;
  assign bus.ram_write_enable      = r_we;
  assign bus.ram_address           = r_addr;
  assign bus.ram_data_in           = r_din;
  assign bus.busy                  = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model, with a behavioural RAM attached.
module tb_ram_port_arbiter;

  localparam int unsigned TB_LIMIT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  ram_port_arbiter #(
    .ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(TB_LIMIT)
  ) u_dut (
    .ram_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Behavioural single-port RAM with a preload port.
  logic [7:0]  mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_address];
  end

  // Reference model state.
  logic [7:0]  shadow [logic [15:0]];
  int          m_phase;
  int          m_win;
  logic [2:0]  m_mask;
  int          m_c3, m_c12;
  logic [7:0]  m_rdval;
  logic [2:0]  e_rdy;
  logic [7:0]  e_d12, e_d3, e_din;
  logic        e_we, e_busy;
  logic [15:0] e_addr;

  function automatic logic [44:0] obs_all();
    return {bus.stage12_read_ready, bus.stage3_read_ready, bus.stage5_save_ready,
            bus.stage12_read_data_out, bus.stage3_read_data_out, bus.ram_write_enable,
            bus.ram_address, bus.ram_data_in, bus.busy};
  endfunction

  task automatic ram_load(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d; shadow[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic drop_all();
    bus.stage12_read = 1'b0; bus.stage3_read = 1'b0; bus.stage5_save = 1'b0;
  endtask

  // One clock edge of the arbitration rules: one access per three cycles,
  // promoted readers first, then stage5 > stage3 > stage12.
  task automatic model_step();
    logic [2:0] elig;
    logic p3, p12;
    e_rdy = 3'b000;
    e_we  = 1'b0;
    if (m_phase == 0) begin
      elig   = {bus.stage5_save, bus.stage3_read, bus.stage12_read} & ~m_mask;
      m_mask = 3'b000;
      if (elig != 3'b000) begin
        p3  = (TB_LIMIT != 0) && elig[1] && (m_c3  >= int'(TB_LIMIT));
        p12 = (TB_LIMIT != 0) && elig[0] && (m_c12 >= int'(TB_LIMIT));
        if (p3) m_win = 1; else if (p12) m_win = 0;
        else if (elig[2]) m_win = 2; else if (elig[1]) m_win = 1; else m_win = 0;
        if (m_win == 1) m_c3 = 0; else if (elig[1] && m_c3 < int'(TB_LIMIT)) m_c3++;
        if (m_win == 0) m_c12 = 0; else if (elig[0] && m_c12 < int'(TB_LIMIT)) m_c12++;
        if (m_win == 2) begin
          e_we = 1'b1; e_addr = bus.stage5_save_address; e_din = bus.stage5_save_data_in;
          shadow[e_addr] = e_din;
        end else begin
          e_addr  = (m_win == 1) ? bus.stage3_read_address : bus.stage12_read_address;
          m_rdval = shadow[e_addr];
        end
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 1;
    end else begin
      m_phase       = 0;
      e_rdy[m_win]  = 1'b1;
      m_mask        = 3'b000;
      m_mask[m_win] = 1'b1;
      if (m_win == 0) e_d12 = m_rdval;
      if (m_win == 1) e_d3  = m_rdval;
    end
    if (!bus.stage3_read)  m_c3  = 0;
    if (!bus.stage12_read) m_c12 = 0;
    e_busy = (m_phase != 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0001;
    bus.stage3_read  = 1'b1; bus.stage3_read_address  = 16'h0002;
    bus.stage5_save  = 1'b1; bus.stage5_save_address  = 16'h0003; bus.stage5_save_data_in = 8'h77;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_all() !== 45'd0) begin
      errors++; $display("FAIL reset_hold outputs got %h exp 0", obs_all());
    end
    drop_all();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_all() !== 45'd0) begin
      errors++; $display("FAIL reset_release outputs got %h exp 0", obs_all());
    end
  endtask

  task automatic test_lone_read();
    ram_load(16'h0010, 8'h2A);
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (bus.ram_address !== 16'h0010) begin
          errors++; $display("FAIL lone_addr got %h exp 0010", bus.ram_address);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.ram_write_enable !== 1'b0) begin
          errors++; $display("FAIL lone_busy_we got %b%b exp 10", bus.busy, bus.ram_write_enable);
        end
      end else if (k == 2) begin
        checks++;
        if (bus.stage12_read_ready !== 1'b0) begin
          errors++; $display("FAIL lone_early_ready got %b exp 0", bus.stage12_read_ready);
        end
      end else if (k == 3) begin
        checks++;
        if (bus.stage12_read_ready !== 1'b1 || bus.stage12_read_data_out !== 8'h2A) begin
          errors++; $display("FAIL lone_ready_data got %b/%h exp 1/2a",
                             bus.stage12_read_ready, bus.stage12_read_data_out);
        end
        bus.stage12_read = 1'b0;
      end else begin
        checks++;
        if (bus.stage12_read_ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.stage12_read_data_out !== 8'h2A) begin
          errors++; $display("FAIL lone_after got rdy %b busy %b data %h exp 0 0 2a",
                             bus.stage12_read_ready, bus.busy, bus.stage12_read_data_out);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    bus.stage5_save = 1'b1; bus.stage5_save_address = 16'h0100; bus.stage5_save_data_in = 8'h55;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (bus.ram_write_enable !== 1'b1 || bus.ram_address !== 16'h0100 || bus.ram_data_in !== 8'h55) begin
          errors++; $display("FAIL wr_issue got we %b addr %h din %h exp 1 0100 55",
                             bus.ram_write_enable, bus.ram_address, bus.ram_data_in);
        end
      end else if (k == 2) begin
        checks++;
        if (bus.ram_write_enable !== 1'b0) begin
          errors++; $display("FAIL wr_we_drop got %b exp 0", bus.ram_write_enable);
        end
      end else if (k == 3) begin
        checks++;
        if (bus.stage5_save_ready !== 1'b1) begin
          errors++; $display("FAIL wr_ready got %b exp 1", bus.stage5_save_ready);
        end
        bus.stage5_save = 1'b0;
        bus.stage3_read = 1'b1; bus.stage3_read_address = 16'h0100;
      end else if (k == 4) begin
        checks++;
        if (bus.ram_address !== 16'h0100 || bus.ram_write_enable !== 1'b0 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL rd_issue got addr %h we %b busy %b exp 0100 0 1",
                             bus.ram_address, bus.ram_write_enable, bus.busy);
        end
      end else if (k == 6) begin
        checks++;
        if (bus.stage3_read_ready !== 1'b1 || bus.stage3_read_data_out !== 8'h55) begin
          errors++; $display("FAIL rd_data got %b/%h exp 1/55",
                             bus.stage3_read_ready, bus.stage3_read_data_out);
        end
        checks++;
        if (bus.stage12_read_data_out !== 8'h2A) begin
          errors++; $display("FAIL wr_no_touch_s12 got %h exp 2a", bus.stage12_read_data_out);
        end
        bus.stage3_read = 1'b0;
      end
    end
  endtask

  task automatic test_all_three();
    int i5 = -1, i3 = -1, i12 = -1, pulses = 0;
    ram_load(16'h0021, 8'hA1);
    ram_load(16'h0022, 8'hB2);
    bus.stage5_save  = 1'b1; bus.stage5_save_address  = 16'h0030; bus.stage5_save_data_in = 8'h99;
    bus.stage3_read  = 1'b1; bus.stage3_read_address  = 16'h0021;
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0022;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (bus.stage5_save_ready)  begin pulses++; if (i5  < 0) i5  = k; bus.stage5_save  = 1'b0; end
      if (bus.stage3_read_ready)  begin pulses++; if (i3  < 0) i3  = k; bus.stage3_read  = 1'b0; end
      if (bus.stage12_read_ready) begin pulses++; if (i12 < 0) i12 = k; bus.stage12_read = 1'b0; end
    end
    checks++; if (i5 != 3)  begin errors++; $display("FAIL all3_s5_slot got %0d exp 3", i5); end
    checks++; if (i3 != 6)  begin errors++; $display("FAIL all3_s3_slot got %0d exp 6", i3); end
    checks++; if (i12 != 9) begin errors++; $display("FAIL all3_s12_slot got %0d exp 9", i12); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL all3_pulses got %0d exp 3", pulses); end
    checks++;
    if (bus.stage3_read_data_out !== 8'hA1 || bus.stage12_read_data_out !== 8'hB2) begin
      errors++; $display("FAIL all3_data got %h/%h exp a1/b2",
                         bus.stage3_read_data_out, bus.stage12_read_data_out);
    end
  endtask

  task automatic test_starvation();
    int q[$];
    int exp_o[5] = '{5, 3, 12, 5, 3};
    int got;
    ram_load(16'h0023, 8'hC3);
    ram_load(16'h0024, 8'hD4);
    bus.stage5_save  = 1'b1; bus.stage5_save_address  = 16'h0031; bus.stage5_save_data_in = 8'h11;
    bus.stage3_read  = 1'b1; bus.stage3_read_address  = 16'h0023;
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0024;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.stage5_save_ready)  q.push_back(5);
      if (bus.stage3_read_ready)  q.push_back(3);
      if (bus.stage12_read_ready) begin q.push_back(12); bus.stage12_read = 1'b0; end
    end
    drop_all();
    checks++;
    if (q.size() != 5) begin errors++; $display("FAIL starve_count got %0d exp 5", q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < q.size()) ? q[i] : -1;
      checks++;
      if (got != exp_o[i]) begin
        errors++; $display("FAIL starve_order[%0d] got %0d exp %0d", i, got, exp_o[i]);
      end
    end
    checks++;
    if (bus.stage12_read_data_out !== 8'hD4) begin
      errors++; $display("FAIL starve_s12_data got %h exp d4", bus.stage12_read_data_out);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hold_through_ready();
    int r3[$];
    int i12 = -1;
    ram_load(16'h0025, 8'hE5);
    ram_load(16'h0026, 8'hF6);
    bus.stage3_read  = 1'b1; bus.stage3_read_address  = 16'h0025;
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0026;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        checks++;
        if (bus.ram_address !== 16'h0026 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL hold_grant got addr %h busy %b exp 0026 1", bus.ram_address, bus.busy);
        end
      end
      if (bus.stage3_read_ready) begin r3.push_back(k); if (k >= 9) bus.stage3_read = 1'b0; end
      if (bus.stage12_read_ready) begin if (i12 < 0) i12 = k; bus.stage12_read = 1'b0; end
    end
    drop_all();
    checks++;
    if (r3.size() != 2) begin errors++; $display("FAIL hold_s3_count got %0d exp 2", r3.size()); end
    else begin
      checks++;
      if (r3[0] != 3 || r3[1] != 9) begin
        errors++; $display("FAIL hold_s3_slots got %0d,%0d exp 3,9", r3[0], r3[1]);
      end
    end
    checks++; if (i12 != 6) begin errors++; $display("FAIL hold_s12_slot got %0d exp 6", i12); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    bus.stage12_read = 1'b1; bus.stage12_read_address = 16'h0010;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_all() !== 45'd0) begin errors++; $display("FAIL rstmid_clear got %h exp 0", obs_all()); end
    rst = 1'b1;
    bus.stage12_read = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.stage12_read_ready !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_quiet[%0d] got rdy %b busy %b exp 0 0",
                           k, bus.stage12_read_ready, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    logic [44:0] exp_v;
    logic [44:0] got_v;
    rst = 1'b0;
    drop_all();
    for (int a = 0; a < 64; a++) ram_load(16'(a), 8'($urandom_range(1, 255)));
    m_phase = 0; m_win = 0; m_mask = 3'b000; m_c3 = 0; m_c12 = 0; m_rdval = '0;
    e_rdy = '0; e_d12 = '0; e_d3 = '0; e_din = '0; e_we = 1'b0; e_busy = 1'b0; e_addr = '0;
    rst = 1'b1;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      got_v = obs_all();
      exp_v = {e_rdy[0], e_rdy[1], e_rdy[2], e_d12, e_d3, e_we, e_addr, e_din, e_busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", cyc, got_v, exp_v);
      end
      if (bus.stage12_read) begin
        if ((e_rdy[0] && $urandom_range(3) != 0) || $urandom_range(15) == 0) bus.stage12_read = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        bus.stage12_read = 1'b1; bus.stage12_read_address = 16'($urandom_range(63));
      end
      if (bus.stage3_read) begin
        if ((e_rdy[1] && $urandom_range(3) != 0) || $urandom_range(15) == 0) bus.stage3_read = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        bus.stage3_read = 1'b1; bus.stage3_read_address = 16'($urandom_range(63));
      end
      if (bus.stage5_save) begin
        if ((e_rdy[2] && $urandom_range(3) != 0) || $urandom_range(15) == 0) bus.stage5_save = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        bus.stage5_save = 1'b1; bus.stage5_save_address = 16'($urandom_range(63));
        bus.stage5_save_data_in = 8'($urandom);
      end
    end
    drop_all();
  endtask

  initial begin
    test_reset();
    test_lone_read();
    test_write_then_read();
    test_all_three();
    test_starvation();
    test_hold_through_ready();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
